// File: rtl/decode_stage_p.sv
// rtl/decode_stage_p.sv - instruction-decode pipeline stage with hazard, branch and halt control
//
// Sits between fetch and execute of the 16-bit-ISA CPU. Holds the IF/ID
// register, a 4 x WORD_W register file, stall logic for load-use and
// branch-operand hazards, branch/jump resolution with fetch redirect and
// IF/ID flush, a sticky halt state, and the registered ID/EX bundle.
//
// Parameters:
//   WORD_W     datapath / PC / register width (>= 16)
//   WB_BYPASS  1: a write-back to the register being read is seen the same cycle
//
// Optional build macro:
//   ID_FWD_EN  branch / JPR / JRL operands take mem_fwd_data on a MEM-stage match
//              instead of stalling (no EX match required)
//
// Ports:
//   clk, reset_n                        clock, asynchronous active-low reset
//   if_valid, if_inst, if_pc_next       fetched instruction and its PC+1
//   stall                               hold fetch PC and IF/ID
//   redirect, redirect_target           taken branch/jump resolved in ID
//   ex_mem_read, ex_reg_write, ex_dest  EX-stage hazard info
//   mem_reg_write, mem_dest             MEM-stage hazard info
//   mem_fwd_data                        MEM-stage result (ID_FWD_EN only)
//   wb_reg_write, wb_dest, wb_data      register-file write port
//   idex_*                              registered ID/EX bundle
//   halted                              sticky, set when HLT leaves ID

module decode_stage_p #(
    parameter int WORD_W    = 16,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_valid,
    input  logic [15:0]       if_inst,
    input  logic [WORD_W-1:0] if_pc_next,
    output logic              stall,
    output logic              redirect,
    output logic [WORD_W-1:0] redirect_target,
    input  logic              ex_mem_read,
    input  logic              ex_reg_write,
    input  logic [1:0]        ex_dest,
    input  logic              mem_reg_write,
    input  logic [1:0]        mem_dest,
    input  logic [WORD_W-1:0] mem_fwd_data,
    input  logic              wb_reg_write,
    input  logic [1:0]        wb_dest,
    input  logic [WORD_W-1:0] wb_data,
    output logic              idex_valid,
    output logic [15:0]       idex_inst,
    output logic [WORD_W-1:0] idex_pc_next,
    output logic [WORD_W-1:0] idex_rdata1,
    output logic [WORD_W-1:0] idex_rdata2,
    output logic [WORD_W-1:0] idex_imm,
    output logic              halted
);

    localparam logic [3:0] OP_BNE   = 4'd0;
    localparam logic [3:0] OP_BEQ   = 4'd1;
    localparam logic [3:0] OP_BGZ   = 4'd2;
    localparam logic [3:0] OP_BLZ   = 4'd3;
    localparam logic [3:0] OP_SWD   = 4'd8;
    localparam logic [3:0] OP_JMP   = 4'd9;
    localparam logic [3:0] OP_JAL   = 4'd10;
    localparam logic [3:0] OP_RTYPE = 4'd15;
    localparam logic [5:0] FN_JPR   = 6'd25;
    localparam logic [5:0] FN_JRL   = 6'd26;
    localparam logic [5:0] FN_HLT   = 6'd29;

    typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

    state_t            state, state_nxt;
    logic              ifid_valid;
    logic [15:0]       ifid_inst;
    logic [WORD_W-1:0] ifid_pc_next;
    logic [WORD_W-1:0] rf [4];

    logic [3:0]        opcode;
    logic [1:0]        rs, rt;
    logic [5:0]        func;
    logic [WORD_W-1:0] imm;
    logic              is_branch, is_jmp_abs, is_rtype, is_jpr, is_jrl, is_hlt;
    logic              is_resolve, uses_rs, uses_rt;
    logic [WORD_W-1:0] rf_rs, rf_rt, op_rs, op_rt;
    logic              ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic              load_use, br_hazard, taken;

    assign opcode = ifid_inst[15:12];
    assign rs     = ifid_inst[11:10];
    assign rt     = ifid_inst[9:8];
    assign func   = ifid_inst[5:0];
    assign imm    = {{(WORD_W-8){ifid_inst[7]}}, ifid_inst[7:0]};

    assign is_branch  = (opcode[3:2] == 2'b00);
    assign is_jmp_abs = (opcode == OP_JMP) || (opcode == OP_JAL);
    assign is_rtype   = (opcode == OP_RTYPE);
    assign is_jpr     = is_rtype && (func == FN_JPR);
    assign is_jrl     = is_rtype && (func == FN_JRL);
    assign is_hlt     = is_rtype && (func == FN_HLT);
    // Instructions whose outcome is decided here need their operands now.
    assign is_resolve = is_branch || is_jpr || is_jrl;
    assign uses_rs    = !(is_jmp_abs || is_hlt);
    assign uses_rt    = is_rtype || (opcode == OP_BNE) || (opcode == OP_BEQ) || (opcode == OP_SWD);

    always_comb begin
        rf_rs = rf[rs];
        rf_rt = rf[rt];
        if (WB_BYPASS && wb_reg_write) begin
            if (wb_dest == rs) rf_rs = wb_data;
            if (wb_dest == rt) rf_rt = wb_data;
        end
    end

    assign ex_hit_rs  = uses_rs && ex_reg_write && (ex_dest == rs);
    assign ex_hit_rt  = uses_rt && ex_reg_write && (ex_dest == rt);
    assign mem_hit_rs = uses_rs && mem_reg_write && (mem_dest == rs);
    assign mem_hit_rt = uses_rt && mem_reg_write && (mem_dest == rt);
    assign load_use   = ex_mem_read && ((uses_rs && (ex_dest == rs)) || (uses_rt && (ex_dest == rt)));

`ifdef ID_FWD_EN
    // An EX match still stalls, so the MEM value only matters without one.
    assign op_rs     = (is_resolve && mem_hit_rs && !ex_hit_rs) ? mem_fwd_data : rf_rs;
    assign op_rt     = (is_resolve && mem_hit_rt && !ex_hit_rt) ? mem_fwd_data : rf_rt;
    assign br_hazard = is_resolve && (ex_hit_rs || ex_hit_rt);
`else
    logic unused_fwd;
    assign unused_fwd = ^mem_fwd_data;
    assign op_rs      = rf_rs;
    assign op_rt      = rf_rt;
    assign br_hazard  = is_resolve && (ex_hit_rs || ex_hit_rt || mem_hit_rs || mem_hit_rt);
`endif

    assign stall = (state == ST_HALT) || (ifid_valid && (load_use || br_hazard));

    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_BNE:         taken = (op_rs != op_rt);
            OP_BEQ:         taken = (op_rs == op_rt);
            OP_BGZ:         taken = !op_rs[WORD_W-1] && (|op_rs);
            OP_BLZ:         taken = op_rs[WORD_W-1];
            OP_JMP, OP_JAL: taken = 1'b1;
            OP_RTYPE:       taken = is_jpr || is_jrl;
            default:        taken = 1'b0;
        endcase
    end

    always_comb begin
        if (is_jmp_abs)
            redirect_target = {ifid_pc_next[WORD_W-1:12], ifid_inst[11:0]};
        else if (is_jpr || is_jrl)
            redirect_target = op_rs;
        else
            redirect_target = ifid_pc_next + imm;
    end

    // stall already covers HALT, so no redirect can escape the halted state.
    assign redirect = ifid_valid && !stall && taken;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) rf[i] <= '0;
        end else if (wb_reg_write) begin
            rf[wb_dest] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || state == ST_HALT) begin
            ifid_valid   <= 1'b0;
            ifid_inst    <= '0;
            ifid_pc_next <= '0;
        end else if (!stall) begin
            if (redirect) begin
                ifid_valid   <= 1'b0;
                ifid_inst    <= '0;
                ifid_pc_next <= '0;
            end else begin
                ifid_valid   <= if_valid;
                ifid_inst    <= if_inst;
                ifid_pc_next <= if_pc_next;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || stall) begin
            idex_valid   <= 1'b0;
            idex_inst    <= '0;
            idex_pc_next <= '0;
            idex_rdata1  <= '0;
            idex_rdata2  <= '0;
            idex_imm     <= '0;
        end else begin
            idex_valid   <= ifid_valid;
            idex_inst    <= ifid_inst;
            idex_pc_next <= ifid_pc_next;
            idex_rdata1  <= op_rs;
            idex_rdata2  <= op_rt;
            idex_imm     <= imm;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_RUN;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:  if (ifid_valid && is_hlt && !stall) state_nxt = ST_HALT;
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        halted = (state == ST_HALT);
    end

endmodule

// File: tb/tb_decode_stage_p.sv
// tb/tb_decode_stage_p.sv - self-checking bench for decode_stage_p
module tb_decode_stage_p;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_valid;
    logic [15:0] if_inst, if_pc_next;
    logic        stall, redirect;
    logic [15:0] redirect_target;
    logic        ex_mem_read, ex_reg_write, mem_reg_write, wb_reg_write;
    logic [1:0]  ex_dest, mem_dest, wb_dest;
    logic [15:0] mem_fwd_data, wb_data;
    logic        idex_valid, halted;
    logic [15:0] idex_inst, idex_pc_next, idex_rdata1, idex_rdata2, idex_imm;

    logic        nb_stall, nb_redirect, nb_idex_valid, nb_halted;
    logic [15:0] nb_redirect_target, nb_idex_inst, nb_idex_pc_next;
    logic [15:0] nb_idex_rdata1, nb_idex_rdata2, nb_idex_imm;

    always #5 clk = ~clk;

    decode_stage_p #(.WORD_W(16), .WB_BYPASS(1'b1)) u_dut (
        .clk(clk), .reset_n(reset_n), .if_valid(if_valid), .if_inst(if_inst),
        .if_pc_next(if_pc_next), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .ex_mem_read(ex_mem_read),
        .ex_reg_write(ex_reg_write), .ex_dest(ex_dest), .mem_reg_write(mem_reg_write),
        .mem_dest(mem_dest), .mem_fwd_data(mem_fwd_data), .wb_reg_write(wb_reg_write),
        .wb_dest(wb_dest), .wb_data(wb_data), .idex_valid(idex_valid),
        .idex_inst(idex_inst), .idex_pc_next(idex_pc_next), .idex_rdata1(idex_rdata1),
        .idex_rdata2(idex_rdata2), .idex_imm(idex_imm), .halted(halted)
    );

    decode_stage_p #(.WORD_W(16), .WB_BYPASS(1'b0)) u_nobyp (
        .clk(clk), .reset_n(reset_n), .if_valid(if_valid), .if_inst(if_inst),
        .if_pc_next(if_pc_next), .stall(nb_stall), .redirect(nb_redirect),
        .redirect_target(nb_redirect_target), .ex_mem_read(ex_mem_read),
        .ex_reg_write(ex_reg_write), .ex_dest(ex_dest), .mem_reg_write(mem_reg_write),
        .mem_dest(mem_dest), .mem_fwd_data(mem_fwd_data), .wb_reg_write(wb_reg_write),
        .wb_dest(wb_dest), .wb_data(wb_data), .idex_valid(nb_idex_valid),
        .idex_inst(nb_idex_inst), .idex_pc_next(nb_idex_pc_next), .idex_rdata1(nb_idex_rdata1),
        .idex_rdata2(nb_idex_rdata2), .idex_imm(nb_idex_imm), .halted(nb_halted)
    );

    typedef struct {
        logic [15:0] inst;
        logic [15:0] pc;
        logic        exmr, exrw;
        logic [1:0]  exd;
        logic        memrw;
        logic [1:0]  memd;
        logic        stall;
        logic        redir;
        logic [15:0] tgt;
        logic [15:0] r1, r2;
    } vec_t;

    typedef struct {
        logic [15:0] inst, pc, r1, r2, imm;
    } idex_exp_t;

    idex_exp_t exp_q[$];
    vec_t      vecs[$];
    int        n_vec  = 0;
    int        n_miss = 0;
    bit        mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] i_ty(input logic [3:0] op, input logic [1:0] s, input logic [1:0] t,
                                         input logic [7:0] im);
        return {op, s, t, im};
    endfunction

    function automatic logic [15:0] r_ty(input logic [1:0] s, input logic [1:0] t, input logic [1:0] d,
                                         input logic [5:0] fn);
        return {4'hF, s, t, d, fn};
    endfunction

    function automatic vec_t mkv(input logic [15:0] inst, input logic [15:0] pc, input logic exmr,
                                 input logic exrw, input logic [1:0] exd, input logic memrw,
                                 input logic [1:0] memd, input logic st, input logic rd,
                                 input logic [15:0] tgt, input logic [15:0] r1, input logic [15:0] r2);
        vec_t v;
        v.inst = inst; v.pc = pc; v.exmr = exmr; v.exrw = exrw; v.exd = exd;
        v.memrw = memrw; v.memd = memd; v.stall = st; v.redir = rd; v.tgt = tgt;
        v.r1 = r1; v.r2 = r2;
        return v;
    endfunction

    task automatic push_exp(input logic [15:0] inst, input logic [15:0] pc, input logic [15:0] r1,
                            input logic [15:0] r2);
        idex_exp_t e;
        e.inst = inst; e.pc = pc; e.r1 = r1; e.r2 = r2;
        e.imm  = {{8{inst[7]}}, inst[7:0]};
        exp_q.push_back(e);
    endtask

    task automatic clear_hazards();
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_dest = 2'd0;
        mem_reg_write = 1'b0; mem_dest = 2'd0;
    endtask

    task automatic wr_reg(input logic [1:0] r, input logic [15:0] d);
        @(negedge clk);
        wb_reg_write = 1'b1; wb_dest = r; wb_data = d;
        @(negedge clk);
        wb_reg_write = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        if_valid = 1'b1; if_inst = v.inst; if_pc_next = v.pc;
        @(negedge clk);
        if_valid = 1'b0;
        ex_mem_read = v.exmr; ex_reg_write = v.exrw; ex_dest = v.exd;
        mem_reg_write = v.memrw; mem_dest = v.memd;
        #1;
        chk($sformatf("v%0d_stall", idx), stall, v.stall);
        if (v.stall) begin
            chk($sformatf("v%0d_redirect_in_stall", idx), redirect, 1'b0);
            @(negedge clk);
            clear_hazards();
            #1;
            chk($sformatf("v%0d_bubble", idx), idex_valid, 1'b0);
            chk($sformatf("v%0d_stall_released", idx), stall, 1'b0);
        end
        chk($sformatf("v%0d_redirect", idx), redirect, v.redir);
        if (v.redir) chk($sformatf("v%0d_target", idx), redirect_target, v.tgt);
        push_exp(v.inst, v.pc, v.r1, v.r2);
        @(negedge clk);
        clear_hazards();
    endtask

    always @(negedge clk) begin
        idex_exp_t e;
        if (mon_en && idex_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_miss++;
                $display("FAIL idex_unexpected: got valid inst %h, expected no instruction", idex_inst);
            end else begin
                e = exp_q.pop_front();
                chk("idex_inst", idex_inst, e.inst);
                chk("idex_pc_next", idex_pc_next, e.pc);
                chk("idex_rdata1", idex_rdata1, e.r1);
                chk("idex_rdata2", idex_rdata2, e.r2);
                chk("idex_imm", idex_imm, e.imm);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Register contents after preload: r0=3 r1=3 r2=FFF0 r3=0007; mem_fwd_data=1234
        vecs.push_back(mkv(i_ty(4'h1,0,1,8'hFE), 16'h0010, 0,0,0, 0,0, 0,1, 16'h000E, 16'h0003, 16'h0003));
        vecs.push_back(mkv(i_ty(4'h1,0,3,8'hFE), 16'h0010, 0,0,0, 0,0, 0,0, 16'h0000, 16'h0003, 16'h0007));
        vecs.push_back(mkv(i_ty(4'h0,0,3,8'h05), 16'h0010, 0,0,0, 0,0, 0,1, 16'h0015, 16'h0003, 16'h0007));
        vecs.push_back(mkv(i_ty(4'h0,0,1,8'h05), 16'h0010, 0,0,0, 0,0, 0,0, 16'h0000, 16'h0003, 16'h0003));
        vecs.push_back(mkv(i_ty(4'h2,3,0,8'h80), 16'h0010, 0,0,0, 0,0, 0,1, 16'hFF90, 16'h0007, 16'h0003));
        vecs.push_back(mkv(i_ty(4'h2,2,0,8'h80), 16'h0010, 0,0,0, 0,0, 0,0, 16'h0000, 16'hFFF0, 16'h0003));
        vecs.push_back(mkv(i_ty(4'h3,2,1,8'h02), 16'h0010, 0,0,0, 0,0, 0,1, 16'h0012, 16'hFFF0, 16'h0003));
        vecs.push_back(mkv(i_ty(4'h3,3,1,8'h02), 16'h0010, 0,0,0, 0,0, 0,0, 16'h0000, 16'h0007, 16'h0003));
        vecs.push_back(mkv(16'h9ABC,              16'h1234, 0,0,0, 0,0, 0,1, 16'h1ABC, 16'hFFF0, 16'hFFF0));
        vecs.push_back(mkv(16'hA005,              16'h2000, 0,0,0, 0,0, 0,1, 16'h2005, 16'h0003, 16'h0003));
`ifdef ID_FWD_EN
        vecs.push_back(mkv(r_ty(3,0,0,6'd25),     16'h0010, 0,0,0, 1,3, 0,1, 16'h1234, 16'h1234, 16'h0003));
`else
        vecs.push_back(mkv(r_ty(3,0,0,6'd25),     16'h0010, 0,0,0, 1,3, 1,1, 16'h0007, 16'h0007, 16'h0003));
`endif
        vecs.push_back(mkv(r_ty(2,0,0,6'd26),     16'h0010, 0,0,0, 0,0, 0,1, 16'hFFF0, 16'hFFF0, 16'h0003));
        vecs.push_back(mkv(r_ty(1,2,3,6'd0),      16'h0010, 0,0,0, 0,0, 0,0, 16'h0000, 16'h0003, 16'hFFF0));
        vecs.push_back(mkv(r_ty(2,1,0,6'd0),      16'h0010, 1,1,2, 0,0, 1,0, 16'h0000, 16'hFFF0, 16'h0003));
        vecs.push_back(mkv(i_ty(4'h8,0,3,8'h04), 16'h0010, 1,1,3, 0,0, 1,0, 16'h0000, 16'h0003, 16'h0007));
        vecs.push_back(mkv(r_ty(1,2,0,6'd0),      16'h0010, 1,1,3, 0,0, 0,0, 16'h0000, 16'h0003, 16'hFFF0));
        vecs.push_back(mkv(16'h9000,              16'h0010, 1,1,0, 0,0, 0,1, 16'h0000, 16'h0003, 16'h0003));
        vecs.push_back(mkv(i_ty(4'h1,0,1,8'hFE), 16'h0010, 0,1,1, 0,0, 1,1, 16'h000E, 16'h0003, 16'h0003));
`ifdef ID_FWD_EN
        vecs.push_back(mkv(i_ty(4'h0,0,3,8'h04), 16'h0010, 0,0,0, 1,0, 0,1, 16'h0014, 16'h1234, 16'h0007));
`else
        vecs.push_back(mkv(i_ty(4'h0,0,3,8'h04), 16'h0010, 0,0,0, 1,0, 1,1, 16'h0014, 16'h0003, 16'h0007));
`endif
        vecs.push_back(mkv(r_ty(1,1,0,6'd0),      16'h0010, 0,1,1, 1,1, 0,0, 16'h0000, 16'h0003, 16'h0003));
        vecs.push_back(mkv(i_ty(4'h7,2,0,8'h01), 16'h0010, 1,1,0, 0,0, 0,0, 16'h0000, 16'hFFF0, 16'h0003));
        vecs.push_back(mkv(i_ty(4'h0,1,0,8'h01), 16'h0010, 0,0,0, 1,2, 0,0, 16'h0000, 16'h0003, 16'h0003));

        reset_n = 1'b0; if_valid = 1'b0; if_inst = '0; if_pc_next = '0;
        clear_hazards();
        wb_reg_write = 1'b0; wb_dest = '0; wb_data = '0; mem_fwd_data = 16'h1234;
        repeat (2) @(negedge clk);
        chk("rst_stall", stall, 1'b0);
        chk("rst_redirect", redirect, 1'b0);
        chk("rst_idex_valid", idex_valid, 1'b0);
        chk("rst_idex_inst", idex_inst, 16'h0);
        chk("rst_halted", halted, 1'b0);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Reset mid-run while IF/ID holds a JMP
        wr_reg(2'd3, 16'h00AA);
        @(negedge clk);
        if_valid = 1'b1; if_inst = 16'h9ABC; if_pc_next = 16'h1234;
        @(negedge clk);
        if_valid = 1'b0;
        #1;
        chk("jmp_pre_reset_redirect", redirect, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_redirect", redirect, 1'b0);
        chk("midrst_stall", stall, 1'b0);
        chk("midrst_idex_pc", idex_pc_next, 16'h0);
        chk("midrst_halted", halted, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("postrst_redirect", redirect, 1'b0);
        @(negedge clk);
        #1;
        chk("postrst_idex_valid", idex_valid, 1'b0);
        chk("postrst_redirect2", redirect, 1'b0);
        // Register file must be cleared by reset (r3 was 00AA)
        run_vec(mkv(r_ty(3,0,0,6'd0), 16'h0030, 0,0,0, 0,0, 0,0, 16'h0, 16'h0, 16'h0), 100);

        // Same-cycle write-back of r1 while ADD reads it
        @(negedge clk);
        if_valid = 1'b1; if_inst = r_ty(1,0,0,6'd0); if_pc_next = 16'h0040;
        @(negedge clk);
        if_valid = 1'b0;
        wb_reg_write = 1'b1; wb_dest = 2'd1; wb_data = 16'h0005;
        #1;
        chk("byp_stall", stall, 1'b0);
        push_exp(r_ty(1,0,0,6'd0), 16'h0040, 16'h0005, 16'h0000);
        @(negedge clk);
        wb_reg_write = 1'b0;
        #1;
        chk("nobyp_idex_valid", nb_idex_valid, 1'b1);
        chk("nobyp_rdata1_old", nb_idex_rdata1, 16'h0000);

        wr_reg(2'd0, 16'h0003);
        wr_reg(2'd1, 16'h0003);
        wr_reg(2'd2, 16'hFFF0);
        wr_reg(2'd3, 16'h0007);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Taken BEQ with a new fetch on the redirect edge: that fetch is flushed
        @(negedge clk);
        if_valid = 1'b1; if_inst = i_ty(4'h1,0,1,8'hFE); if_pc_next = 16'h0010;
        @(negedge clk);
        if_inst = r_ty(1,2,0,6'd0); if_pc_next = 16'h0011;
        #1;
        chk("flush_redirect", redirect, 1'b1);
        chk("flush_target", redirect_target, 16'h000E);
        push_exp(i_ty(4'h1,0,1,8'hFE), 16'h0010, 16'h0003, 16'h0003);
        @(negedge clk);
        if_valid = 1'b0;
        #1;
        chk("flush_no_redirect", redirect, 1'b0);
        @(negedge clk);
        #1;
        chk("flush_bubble", idex_valid, 1'b0);

        // Not-taken BEQ: the following fetch is kept and advances
        @(negedge clk);
        if_valid = 1'b1; if_inst = i_ty(4'h1,0,3,8'hFE); if_pc_next = 16'h0010;
        @(negedge clk);
        if_inst = r_ty(1,2,0,6'd0); if_pc_next = 16'h0011;
        #1;
        chk("noflush_redirect", redirect, 1'b0);
        push_exp(i_ty(4'h1,0,3,8'hFE), 16'h0010, 16'h0003, 16'h0007);
        @(negedge clk);
        if_valid = 1'b0;
        #1;
        chk("noflush_stall", stall, 1'b0);
        push_exp(r_ty(1,2,0,6'd0), 16'h0011, 16'h0003, 16'hFFF0);
        repeat (2) @(negedge clk);

        // HLT followed by continuous valid fetches (a JMP)
        @(negedge clk);
        if_valid = 1'b1; if_inst = r_ty(0,0,0,6'd29); if_pc_next = 16'h0050;
        @(negedge clk);
        if_inst = 16'h9ABC; if_pc_next = 16'h0051;
        #1;
        chk("hlt_halted_pre", halted, 1'b0);
        chk("hlt_stall_pre", stall, 1'b0);
        push_exp(r_ty(0,0,0,6'd29), 16'h0050, 16'h0003, 16'h0003);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("halt%0d_halted", k), halted, 1'b1);
            chk($sformatf("halt%0d_stall", k), stall, 1'b1);
            chk($sformatf("halt%0d_redirect", k), redirect, 1'b0);
            if (k > 0) chk($sformatf("halt%0d_idex_valid", k), idex_valid, 1'b0);
        end
        reset_n = 1'b0;
        #1;
        chk("halt_rst_halted", halted, 1'b0);
        @(negedge clk);
        if_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        chk("halt_rst_stall", stall, 1'b0);
        chk("halt_rst_halted2", halted, 1'b0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
